addsub_sequencer: RTL and testbench

Sequential operand loader and result capture stage for the N-bit two's-complement adder/subtractor. It debounces nothing but synchronizes and edge-detects a single enter button. It steps through load-X, load-Y/op and execute phases, and drives registered operands and mode into the adder/subtractor. It captures sum, carry-out and overflow into display registers, keeps a sticky overflow flag, and counts completed operations. It sits between the board switches/button and the adder/subtractor and seven-segment display logic.

---
 rtl/addsub_pkg.sv | 13 +
 rtl/addsub_sequencer_btn_pulse.sv | 28 ++
 rtl/addsub_sequencer.sv | 135 +++++++++++++
 tb/tb_addsub_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the adder/subtractor front end: FSM state encoding.
package addsub_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      S_LOAD_X = 2'b00,
      S_LOAD_Y = 2'b01,
      S_EXEC   = 2'b10,
      S_SHOW   = 2'b11
   } state_e;

endpackage

// File: rtl/addsub_sequencer_btn_pulse.sv
// Synchronizes the raw enter button and emits a one-cycle pulse on its rising edge.
module btn_pulse (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic pulse_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   // Flops reset high so a button already held during reset looks "old" and never pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/addsub_sequencer.sv
// Steps through load-X, load-Y/op, execute and show phases around an external
// combinational adder/subtractor, capturing its result into display registers.
module addsub_sequencer
   import addsub_pkg::*;
#(
   parameter int N     = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_enter,
   input  logic [N-1:0]     sw,
   input  logic             sw_sub,
   input  logic [N-1:0]     s_in,
   input  logic             cout_in,
   input  logic             ovf_in,
   output logic [N-1:0]     x_out,
   output logic [N-1:0]     y_out,
   output logic             add_n_out,
   output logic [N-1:0]     result,
   output logic             result_cout,
   output logic             result_ovf,
   output logic             ovf_sticky,
   output logic [CNT_W-1:0] op_count,
   output logic [1:0]       state,
   output logic             done
);

   state_e state_q, state_d;
   logic   pulse;
   logic   loadX, loadY, capture;

   logic [N-1:0]     x_q, x_d;
   logic [N-1:0]     y_q, y_d;
   logic             addN_q, addN_d;
   logic [N-1:0]     result_q, result_d;
   logic             resultCout_q, resultCout_d;
   logic             resultOvf_q, resultOvf_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] opCount_q, opCount_d;

   btn_pulse u_btn_pulse (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_enter),
      .pulse_o (pulse)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_LOAD_X;
      else     state_q <= state_d;
   end

   // S_EXEC always advances; a pulse arriving there is deliberately ignored.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_LOAD_X: if (pulse) state_d = S_LOAD_Y;
         S_LOAD_Y: if (pulse) state_d = S_EXEC;
         S_EXEC:              state_d = S_SHOW;
         S_SHOW:   if (pulse) state_d = S_LOAD_X;
         default:             state_d = S_LOAD_X;
      endcase
   end

   always_comb begin
      loadX   = 1'b0;
      loadY   = 1'b0;
      capture = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         S_LOAD_X: loadX   = pulse;
         S_LOAD_Y: loadY   = pulse;
         S_EXEC:   capture = 1'b1;
         S_SHOW:   done    = 1'b1;
         default:  done    = 1'b0;
      endcase
   end

   always_comb begin
      x_d          = x_q;
      y_d          = y_q;
      addN_d       = addN_q;
      result_d     = result_q;
      resultCout_d = resultCout_q;
      resultOvf_d  = resultOvf_q;
      sticky_d     = sticky_q;
      opCount_d    = opCount_q;
      if (loadX) x_d = sw;
      if (loadY) begin
         y_d    = sw;
         addN_d = sw_sub;
      end
      if (capture) begin
         result_d     = s_in;
         resultCout_d = cout_in;
         resultOvf_d  = ovf_in;
         sticky_d     = sticky_q | ovf_in;
         opCount_d    = opCount_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q          <= '0;
         y_q          <= '0;
         addN_q       <= 1'b0;
         result_q     <= '0;
         resultCout_q <= 1'b0;
         resultOvf_q  <= 1'b0;
         sticky_q     <= 1'b0;
         opCount_q    <= '0;
      end else begin
         x_q          <= x_d;
         y_q          <= y_d;
         addN_q       <= addN_d;
         result_q     <= result_d;
         resultCout_q <= resultCout_d;
         resultOvf_q  <= resultOvf_d;
         sticky_q     <= sticky_d;
         opCount_q    <= opCount_d;
      end
   end

   assign x_out       = x_q;
   assign y_out       = y_q;
   assign add_n_out   = addN_q;
   assign result      = result_q;
   assign result_cout = resultCout_q;
   assign result_ovf  = resultOvf_q;
   assign ovf_sticky  = sticky_q;
   assign op_count    = opCount_q;
   assign state       = state_q;

endmodule

// File: tb/tb_addsub_sequencer.sv
// Scoreboard bench for addsub_sequencer: stimulus pushes expected results computed
// arithmetically, a monitor pops and compares each time done rises.
module tb_addsub_sequencer;

   localparam int N     = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             btnEnter;
   logic [N-1:0]     sw;
   logic             swSub;
   logic [N-1:0]     sIn;
   logic             coutIn;
   logic             ovfIn;
   logic [N-1:0]     xOut;
   logic [N-1:0]     yOut;
   logic             addNOut;
   logic [N-1:0]     result;
   logic             resultCout;
   logic             resultOvf;
   logic             ovfSticky;
   logic [CNT_W-1:0] opCount;
   logic [1:0]       state;
   logic             done;

   typedef struct {
      logic [N-1:0]     res;
      logic             cout;
      logic             ovf;
      logic             sticky;
      logic [CNT_W-1:0] cnt;
      logic [N-1:0]     x;
      logic [N-1:0]     y;
      logic             sub;
   } exp_t;

   exp_t expQ[$];
   int   compared   = 0;
   int   mismatched = 0;
   logic             modelSticky;
   int               modelCount;
   logic [N-1:0]     lastY;

   addsub_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_enter   (btnEnter),
      .sw          (sw),
      .sw_sub      (swSub),
      .s_in        (sIn),
      .cout_in     (coutIn),
      .ovf_in      (ovfIn),
      .x_out       (xOut),
      .y_out       (yOut),
      .add_n_out   (addNOut),
      .result      (result),
      .result_cout (resultCout),
      .result_ovf  (resultOvf),
      .ovf_sticky  (ovfSticky),
      .op_count    (opCount),
      .state       (state),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Stand-in for the external combinational adder/subtractor.
   logic [N:0] sumWide;
   always_comb begin
      sumWide = addNOut ? ({1'b0, xOut} + {1'b0, ~yOut} + (N+1)'(1))
                        : ({1'b0, xOut} + {1'b0, yOut});
   end
   assign sIn    = sumWide[N-1:0];
   assign coutIn = sumWide[N];
   assign ovfIn  = addNOut ? ((xOut[N-1] != yOut[N-1]) && (sIn[N-1] != xOut[N-1]))
                           : ((xOut[N-1] == yOut[N-1]) && (sIn[N-1] != xOut[N-1]));

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic exp_t refOp(input int x, input int y, input bit sub);
      exp_t e;
      int sx, sy, r;
      sx = (x >= 8) ? x - 16 : x;
      sy = (y >= 8) ? y - 16 : y;
      r  = sub ? sx - sy : sx + sy;
      e.res  = N'(r);
      e.cout = sub ? (x >= y) : ((x + y) > 15);
      e.ovf  = (r > 7) || (r < -8);
      e.x    = N'(x);
      e.y    = N'(y);
      e.sub  = sub;
      e.sticky = 1'b0;
      e.cnt    = '0;
      return e;
   endfunction

   // Monitor: compares the scoreboard head each time a fresh result is shown.
   initial begin
      logic donePrev;
      exp_t e;
      donePrev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            donePrev = 1'b0;
         end else begin
            if (done && !donePrev) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpectedResult", 32'(done), 32'(0));
               end else begin
                  e = expQ.pop_front();
                  checkOutput("result",     32'(result),     32'(e.res));
                  checkOutput("resultCout", 32'(resultCout), 32'(e.cout));
                  checkOutput("resultOvf",  32'(resultOvf),  32'(e.ovf));
                  checkOutput("ovfSticky",  32'(ovfSticky),  32'(e.sticky));
                  checkOutput("opCount",    32'(opCount),    32'(e.cnt));
                  checkOutput("xOut",       32'(xOut),       32'(e.x));
                  checkOutput("yOut",       32'(yOut),       32'(e.y));
                  checkOutput("addNOut",    32'(addNOut),    32'(e.sub));
                  checkOutput("showState",  32'(state),      32'(3));
               end
            end
            donePrev = done;
         end
      end
   end

   task automatic pressButton();
      @(negedge clk);
      btnEnter = 1'b1;
      repeat (3) @(negedge clk);
      btnEnter = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic applyReset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      modelSticky = 1'b0;
      modelCount  = 0;
      lastY       = '0;
      expQ.delete();
   endtask

   // One full operation; switches are scrambled between presses to prove they are ignored.
   task automatic applyStimulus(input int x, input int y, input bit sub);
      exp_t e;
      sw = N'(x);
      pressButton();
      checkOutput("stateAfterX", 32'(state), 32'(1));
      sw    = N'($urandom_range(0, 15));
      swSub = 1'($urandom_range(0, 1));
      repeat (2) @(negedge clk);
      checkOutput("yHold", 32'(yOut), 32'(lastY));
      e = refOp(x, y, sub);
      modelSticky = modelSticky | e.ovf;
      modelCount  = (modelCount + 1) % 256;
      e.sticky = modelSticky;
      e.cnt    = CNT_W'(modelCount);
      expQ.push_back(e);
      sw    = N'(y);
      swSub = sub;
      pressButton();
      checkOutput("stateAfterExec", 32'(state), 32'(3));
      sw    = N'($urandom_range(0, 15));
      swSub = 1'($urandom_range(0, 1));
      pressButton();
      checkOutput("stateAfterShow", 32'(state), 32'(0));
      lastY = N'(y);
   endtask

   initial begin
      rst = 1'b1; btnEnter = 1'b0; sw = '0; swSub = 1'b0;
      modelSticky = 1'b0; modelCount = 0; lastY = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rstState",  32'(state),      32'(0));
      checkOutput("rstX",      32'(xOut),       32'(0));
      checkOutput("rstY",      32'(yOut),       32'(0));
      checkOutput("rstAddN",   32'(addNOut),    32'(0));
      checkOutput("rstResult", 32'(result),     32'(0));
      checkOutput("rstCout",   32'(resultCout), 32'(0));
      checkOutput("rstOvf",    32'(resultOvf),  32'(0));
      checkOutput("rstSticky", 32'(ovfSticky),  32'(0));
      checkOutput("rstCount",  32'(opCount),    32'(0));
      checkOutput("rstDone",   32'(done),       32'(0));

      // Held button: one transition, two edges after the rise.
      sw = 4'hA;
      @(negedge clk); btnEnter = 1'b1;
      @(negedge clk); checkOutput("heldEdge1", 32'(state), 32'(0));
      @(negedge clk); checkOutput("heldEdge2", 32'(state), 32'(0));
      @(negedge clk); checkOutput("heldEdge3", 32'(state), 32'(1));
      repeat (50) @(negedge clk);
      checkOutput("heldOnce", 32'(state), 32'(1));
      checkOutput("heldX",    32'(xOut),  32'(4'hA));
      btnEnter = 1'b0;
      repeat (3) @(negedge clk);
      applyReset();

      // Button held through reset release must not pulse.
      @(negedge clk); rst = 1'b1; btnEnter = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("heldThroughRst", 32'(state), 32'(0));
      btnEnter = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("heldThroughRstRelease", 32'(state), 32'(0));

      // Overflowing op, then reset while in load-Y clears everything.
      applyStimulus(7, 1, 1'b0);
      sw = 4'h5;
      pressButton();
      checkOutput("midOpState", 32'(state), 32'(1));
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midRstState",  32'(state),     32'(0));
      checkOutput("midRstX",      32'(xOut),      32'(0));
      checkOutput("midRstCount",  32'(opCount),   32'(0));
      checkOutput("midRstSticky", 32'(ovfSticky), 32'(0));
      checkOutput("midRstResult", 32'(result),    32'(0));
      rst = 1'b0;
      modelSticky = 1'b0; modelCount = 0; lastY = '0;

      // Reset landing on the same edge as the pulse wins.
      sw = 4'h6;
      @(negedge clk); btnEnter = 1'b1;
      @(negedge clk);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      checkOutput("rstVsPulseState", 32'(state), 32'(0));
      checkOutput("rstVsPulseX",     32'(xOut),  32'(0));
      repeat (4) @(negedge clk);
      btnEnter = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("rstVsPulseAfter", 32'(state), 32'(0));

      applyReset();
      applyStimulus(3, 2, 1'b0);
      applyStimulus(7, 1, 1'b0);
      applyStimulus(1, 1, 1'b0);
      applyStimulus(3, 5, 1'b1);
      applyStimulus(8, 1, 1'b1);
      applyStimulus(0, 0, 1'b1);
      for (int i = 0; i < 255; i++) begin
         applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end

      repeat (4) @(negedge clk);
      checkOutput("scoreboardDrained", 32'(expQ.size()), 32'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
